// File: rtl/setare_ceas.sv
// setare_ceas: button-driven time/alarm setting controller.
//   Three raw buttons go through a 2-flop synchronizer and a debounce counter each.
//   A debounced 0->1 edge is a press event, and press events drive the edit FSM.
//   Latency: a clean raw edge first sampled at edge 1 changes the outputs after edge DEBOUNCE_CYCLES+3.
//   Backpressure: none. Events are consumed in the cycle they occur. Outputs are all registered.
// Ports:
//   clock, reset_n           : single clock, asynchronous active-low reset
//   buton_mod/alarma/inc     : raw push-buttons
//   ore, minute              : running time, preloaded when a time edit starts
//   ore_setare, minute_setare: edit registers shown by the display mux
//   semnal_setare(_a)        : high while editing time (alarm)
//   incarca, incarca_a       : one-cycle commit strobes (time load / alarm register update)
//   ore_alarma, minute_alarma: stored alarm
// Optional feature: define SETARE_AUTO_REPEAT_EN to auto-repeat a held buton_inc every REPEAT_CYCLES.
module setare_ceas #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       buton_mod,
  input  logic       buton_alarma,
  input  logic       buton_inc,
  input  logic [4:0] ore,
  input  logic [5:0] minute,
  output logic [4:0] ore_setare,
  output logic [5:0] minute_setare,
  output logic       semnal_setare,
  output logic       semnal_setare_a,
  output logic       incarca,
  output logic       incarca_a,
  output logic [4:0] ore_alarma,
  output logic [5:0] minute_alarma
);

  typedef enum logic [2:0] {IDLE, T_ORE, T_MIN, A_ORE, A_MIN} state_t;

  state_t      state;

  // Button index: 0 = mod, 1 = alarma, 2 = inc
  logic [2:0]  raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  lvl;
  logic [2:0]  lvl_d;
  logic [15:0] deb_cnt [3];
  logic [2:0]  press;

  logic        p_mod;
  logic        p_al;
  logic        p_inc;
  logic        inc_ev;

  assign raw = {buton_inc, buton_alarma, buton_mod};

  // The debounced level flips only after sync2 has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles. Any agreement restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          lvl[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Both lvl and lvl_d are registered, so the press events come straight from flops.
  assign press = lvl & ~lvl_d;
  assign p_mod = press[0];
  assign p_al  = press[1];
  assign p_inc = press[2];

`ifdef SETARE_AUTO_REPEAT_EN
  logic [23:0] rep_cnt;
  logic        editing;
  logic        advance;
  logic        rep_tick;

  assign editing  = (state != IDLE);
  assign advance  = (((state == T_ORE) || (state == T_MIN)) && p_mod) ||
                    (((state == A_ORE) || (state == A_MIN)) && p_al);
  // The first repeat fires REPEAT_CYCLES after the press event, and further repeats follow at the same period.
  assign rep_tick = editing && lvl[2] && !p_inc && (rep_cnt == REPEAT_CYCLES - 24'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= '0;
    end else if (!editing || !lvl[2] || p_inc || advance || rep_tick) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 24'd1;
    end
  end

  assign inc_ev = p_inc | rep_tick;
`else
  // REPEAT_CYCLES has no effect in this build.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
  assign inc_ev = p_inc;
`endif

  function automatic logic [4:0] next_hour(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] next_min(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  // Edit FSM. Advance/commit buttons take priority over increment in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ore_setare      <= '0;
      minute_setare   <= '0;
      semnal_setare   <= 1'b0;
      semnal_setare_a <= 1'b0;
      incarca         <= 1'b0;
      incarca_a       <= 1'b0;
      ore_alarma      <= '0;
      minute_alarma   <= '0;
    end else begin
      incarca   <= 1'b0;
      incarca_a <= 1'b0;
      case (state)
        IDLE: begin
          if (p_mod) begin
            state         <= T_ORE;
            semnal_setare <= 1'b1;
            // Out-of-range running values preload as 0.
            ore_setare    <= (ore > 5'd23) ? 5'd0 : ore;
            minute_setare <= (minute > 6'd59) ? 6'd0 : minute;
          end else if (p_al) begin
            state           <= A_ORE;
            semnal_setare_a <= 1'b1;
            ore_setare      <= ore_alarma;
            minute_setare   <= minute_alarma;
          end
        end
        T_ORE: begin
          if (p_mod)       state      <= T_MIN;
          else if (inc_ev) ore_setare <= next_hour(ore_setare);
        end
        T_MIN: begin
          if (p_mod) begin
            state         <= IDLE;
            semnal_setare <= 1'b0;
            incarca       <= 1'b1;
          end else if (inc_ev) begin
            minute_setare <= next_min(minute_setare);
          end
        end
        A_ORE: begin
          if (p_al)        state      <= A_MIN;
          else if (inc_ev) ore_setare <= next_hour(ore_setare);
        end
        A_MIN: begin
          if (p_al) begin
            state           <= IDLE;
            semnal_setare_a <= 1'b0;
            incarca_a       <= 1'b1;
            ore_alarma      <= ore_setare;
            minute_alarma   <= minute_setare;
          end else if (inc_ev) begin
            minute_setare <= next_min(minute_setare);
          end
        end
        default: begin
          state           <= IDLE;
          semnal_setare   <= 1'b0;
          semnal_setare_a <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_setare_ceas.sv
// tb_setare_ceas: scoreboard bench for setare_ceas with DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8.
//   The stimulus pushes each expected output change together with the cycle on which it should appear.
//   A monitor on the falling edge pops one entry per observed output change and compares it.
module tb_setare_ceas;

  typedef struct packed {
    logic [4:0] ore_s;
    logic [5:0] min_s;
    logic       s;
    logic       sa;
    logic       ld;
    logic       ld_a;
    logic [4:0] ore_al;
    logic [5:0] min_al;
  } out_t;

  typedef struct {
    int   cyc;
    out_t val;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] btn;
  logic [4:0] ore;
  logic [5:0] minute;
  logic [4:0] ore_setare;
  logic [5:0] minute_setare;
  logic       semnal_setare;
  logic       semnal_setare_a;
  logic       incarca;
  logic       incarca_a;
  logic [4:0] ore_alarma;
  logic [5:0] minute_alarma;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  out_t prev;
  out_t outs;
  exp_t sb_q[$];

  setare_ceas #(.DEBOUNCE_CYCLES(16'd4), .REPEAT_CYCLES(24'd8)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .buton_mod      (btn[0]),
    .buton_alarma   (btn[1]),
    .buton_inc      (btn[2]),
    .ore            (ore),
    .minute         (minute),
    .ore_setare     (ore_setare),
    .minute_setare  (minute_setare),
    .semnal_setare  (semnal_setare),
    .semnal_setare_a(semnal_setare_a),
    .incarca        (incarca),
    .incarca_a      (incarca_a),
    .ore_alarma     (ore_alarma),
    .minute_alarma  (minute_alarma)
  );

  assign outs = '{ore_s: ore_setare, min_s: minute_setare, s: semnal_setare, sa: semnal_setare_a,
                  ld: incarca, ld_a: incarca_a, ore_al: ore_alarma, min_al: minute_alarma};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic out_t mk(input int oh, input int om, input int s, input int sa,
                              input int ld, input int lda, input int ah, input int am);
    out_t o;
    o.ore_s  = 5'(oh);
    o.min_s  = 6'(om);
    o.s      = 1'(s);
    o.sa     = 1'(sa);
    o.ld     = 1'(ld);
    o.ld_a   = 1'(lda);
    o.ore_al = 5'(ah);
    o.min_al = 6'(am);
    return o;
  endfunction

  // Monitor: every change on the output bundle must match the next expected entry, both in value and in cycle.
  always @(negedge clock) begin
    if (mon_en && (outs !== prev)) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change: cycle %0d got %h, no change expected", cyc, outs);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ((outs !== e.val) || (cyc != e.cyc)) begin
          failures++;
          $display("FAIL scoreboard: got %h at cycle %0d, required %h at cycle %0d",
                   outs, cyc, e.val, e.cyc);
        end
      end
      prev = outs;
    end
  end

  // An expected change that appears d edges after the current point. Call this just after a negedge.
  task automatic expect_at(input int d, input out_t v);
    exp_t e;
    e.cyc = cyc + d;
    e.val = v;
    sb_q.push_back(e);
  endtask

  // Hold raw buttons b high for len cycles, then keep them low for gap cycles.
  task automatic press(input logic [2:0] b, input int len, input int gap);
    btn = b;
    repeat (len) @(negedge clock);
    btn = 3'b000;
    repeat (gap) @(negedge clock);
  endtask

  localparam logic [2:0] MOD = 3'b001;
  localparam logic [2:0] ALM = 3'b010;
  localparam logic [2:0] INC = 3'b100;

  initial begin
    int mexp;
    reset_n = 1'b0;
    btn     = 3'b000;
    ore     = 5'd22;
    minute  = 6'd58;
    repeat (3) @(negedge clock);
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h required 0", outs);
    end
    reset_n = 1'b1;
    prev    = outs;
    mon_en  = 1'b1;
    repeat (2) @(negedge clock);

    // 1: time edit from 22:58. Commit at 00:01.
    expect_at(7, mk(22, 58, 1, 0, 0, 0, 0, 0)); press(MOD, 6, 14);
    expect_at(7, mk(23, 58, 1, 0, 0, 0, 0, 0)); press(INC, 6, 14);
    expect_at(7, mk(0, 58, 1, 0, 0, 0, 0, 0));  press(INC, 6, 14);
    press(MOD, 6, 14);
    expect_at(7, mk(0, 59, 1, 0, 0, 0, 0, 0));  press(INC, 6, 14);
    expect_at(7, mk(0, 0, 1, 0, 0, 0, 0, 0));   press(INC, 6, 14);
    expect_at(7, mk(0, 1, 1, 0, 0, 0, 0, 0));   press(INC, 6, 14);
    expect_at(7, mk(0, 1, 0, 0, 1, 0, 0, 0));
    expect_at(8, mk(0, 1, 0, 0, 0, 0, 0, 0));   press(MOD, 6, 14);

    // 2: bounce rejection in T_MIN, followed by a long press that takes effect exactly 7 edges after first sample.
    expect_at(7, mk(22, 58, 1, 0, 0, 0, 0, 0)); press(MOD, 6, 14);
    press(MOD, 6, 14);
    press(INC, 3, 10);
    press(INC, 3, 10);
    expect_at(7, mk(22, 59, 1, 0, 0, 0, 0, 0)); press(INC, 10, 14);
    expect_at(7, mk(22, 59, 0, 0, 1, 0, 0, 0));
    expect_at(8, mk(22, 59, 0, 0, 0, 0, 0, 0)); press(MOD, 6, 14);

    // 3: alarm edit to 05:00. A later inc press in IDLE is ignored.
    expect_at(7, mk(0, 0, 0, 1, 0, 0, 0, 0)); press(ALM, 6, 14);
    for (int i = 1; i <= 5; i++) begin
      expect_at(7, mk(i, 0, 0, 1, 0, 0, 0, 0)); press(INC, 6, 14);
    end
    press(ALM, 6, 14);
    expect_at(7, mk(5, 0, 0, 0, 0, 1, 5, 0));
    expect_at(8, mk(5, 0, 0, 0, 0, 0, 5, 0)); press(ALM, 6, 14);
    press(INC, 6, 14);

    // 5: reset in A_MIN aborts the edit and issues no strobe.
    expect_at(7, mk(5, 0, 0, 1, 0, 0, 5, 0)); press(ALM, 6, 14);
    press(ALM, 6, 14);
    expect_at(7, mk(5, 1, 0, 1, 0, 0, 5, 0)); press(INC, 6, 14);
    expect_at(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL async_reset: got %h required 0", outs);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);

    // 4: mod and alarma together in IDLE -> time edit. Out-of-range hours preload as 0. alarma is ignored.
    ore    = 5'd30;
    minute = 6'd10;
    expect_at(7, mk(0, 10, 1, 0, 0, 0, 0, 0)); press(MOD | ALM, 6, 14);
    press(ALM, 6, 14);
    press(MOD, 6, 14);

    // 6: holding inc in T_MIN from 10. Auto-repeat adds one step every 8 cycles.
    expect_at(7, mk(0, 11, 1, 0, 0, 0, 0, 0));
`ifdef SETARE_AUTO_REPEAT_EN
    for (int k = 1; k <= 4; k++) expect_at(7 + 8 * k, mk(0, 11 + k, 1, 0, 0, 0, 0, 0));
    mexp = 15;
`else
    mexp = 11;
`endif
    press(INC, 36, 20);
    expect_at(7, mk(0, mexp, 0, 0, 1, 0, 0, 0));
    expect_at(8, mk(0, mexp, 0, 0, 0, 0, 0, 0)); press(MOD, 6, 14);

    repeat (10) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL missing_changes: got %0d expected changes never seen, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/setare_ceas.md
# setare_ceas

Button-driven time/alarm setting controller; the input-side counterpart of the display path. It debounces three push-buttons and runs an edit state machine that produces `ore_setare`/`minute_setare` and the `semnal_setare`/`semnal_setare_a` flags consumed by the display mux. When an edit is committed, it issues one-cycle load strobes to the timekeeping counter or to its internal alarm register. Sits between the board buttons and the clock counter/display blocks.

## Interface

- `DEBOUNCE_CYCLES`, 16'd50000, consecutive stable cycles required before a synchronized button level is accepted
- `REPEAT_CYCLES`, 24'd5000000, auto-repeat period for held `buton_inc` (used only with the macro)

- `clock`  in  1  system clock; single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `buton_mod`  in  1  raw button: enter/advance/commit time edit
- `buton_alarma`  in  1  raw button: enter/advance/commit alarm edit
- `buton_inc`  in  1  raw button: increment the selected field
- `ore`  in  5  current running hours, preloaded on time-edit entry
- `minute`  in  6  current running minutes, preloaded on time-edit entry
- `ore_setare`  out  5  hours being edited
- `minute_setare`  out  6  minutes being edited
- `semnal_setare`  out  1  high while editing time
- `semnal_setare_a`  out  1  high while editing alarm
- `incarca`  out  1  one-cycle strobe: load `ore_setare`/`minute_setare` into the time counter
- `incarca_a`  out  1  one-cycle strobe: alarm register updated
- `ore_alarma`  out  5  stored alarm hours
- `minute_alarma`  out  6  stored alarm minutes

## Operation

- Each button passes through a 2-flop synchronizer, then a per-button debounce counter. The debounced level flips only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any return to the current level clears the counter.
- A press event is a debounced 0->1 transition, one cycle wide.
- States: IDLE, T_ORE, T_MIN, A_ORE, A_MIN.
- IDLE:
  - mod press -> T_ORE; edit regs load from `ore`/`minute`.
  - alarma press -> A_ORE; edit regs load from `ore_alarma`/`minute_alarma`.
  - inc press ignored.
- T_ORE --mod--> T_MIN --mod--> IDLE with `incarca`=1 for exactly one cycle.
- A_ORE --alarma--> A_MIN --alarma--> IDLE; the alarm regs take the edit values and `incarca_a`=1 for one cycle.
- Increment in an *_ORE state: hours 23 -> 0, else +1. Increment in an *_MIN state: minutes 59 -> 0, else +1.
- `semnal_setare` = T_ORE|T_MIN; `semnal_setare_a` = A_ORE|A_MIN. Never both high.
- `ore_setare`/`minute_setare` hold their last values in IDLE and remain valid during the `incarca`/`incarca_a` cycle.
- Boundary conditions:
  - mod and alarma pressed in the same cycle in IDLE: mod wins.
  - alarma ignored in T_* states; mod ignored in A_* states.
  - Advance and inc in the same cycle: advance wins, inc dropped.
  - Preload with `ore`>23 or `minute`>59: the out-of-range field loads as 0.
  - `reset_n` low at any time, including mid-edit: the edit is aborted and no strobe is issued.

## Timing

- Reset values: state IDLE; every output 0 (alarm 00:00); synchronizers, debounced levels and counters 0.
- Clean raw edge sampled first at edge 1 -> the FSM output change is visible after edge `DEBOUNCE_CYCLES`+3, exactly.
- `incarca`/`incarca_a` assert on the same edge the state returns to IDLE and deassert on the next edge.
- A button held through reset release counts as a fresh press after the debounce latency.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration

- `SETARE_AUTO_REPEAT_EN` defined:
  - While the debounced `buton_inc` stays high in an edit state, an extra inc event fires `REPEAT_CYCLES` cycles after the press event, then every `REPEAT_CYCLES`.
  - Release or a state change resets the repeat timer.
- Not defined: exactly one increment per press; `REPEAT_CYCLES` unused and the repeat timer absent.

## Test plan

Bench uses `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=8.

1. Time edit with `ore`=22, `minute`=58: press mod, inc x2, mod, inc x3, mod -> single-cycle `incarca` with `ore_setare`=0 and `minute_setare`=1; `semnal_setare` high from entry until commit.
2. Bounce rejection: 3-cycle pulses on `buton_inc` in T_MIN -> `minute_setare` unchanged. A 10-cycle press -> +1, output changing exactly 7 edges after the first sampled high.
3. Alarm edit: press alarma, inc x5, alarma, alarma -> `incarca_a` pulse; `ore_alarma`=5, `minute_alarma`=0, held after return to IDLE. `incarca` stays 0.
4. mod and alarma pressed in the same cycle in IDLE -> T_ORE; `semnal_setare`=1, `semnal_setare_a`=0. A later alarma press has no effect.
5. `reset_n` pulsed low in A_MIN -> all outputs 0 immediately (asynchronous); no `incarca_a`; IDLE after release.
6. Macro defined: hold inc for 40 cycles after the press event in T_MIN from 10 -> `minute_setare`=15. Macro undefined, same stimulus -> 11.
